// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder sequencer: streams a WIDTH-bit add through an external 4-bit
// ripple-carry adder one nibble per cycle (LSB first), then presents sum and carry-out.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [3:0]       rca_a,
   output logic [3:0]       rca_b,
   output logic             rca_cin,
   input  logic [3:0]       rca_s,
   input  logic             rca_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        idx;
   logic [NIBBLES-1:0][3:0] a_reg;
   logic [NIBBLES-1:0][3:0] b_reg;
   logic [NIBBLES-1:0][3:0] sum_reg;
   logic                    carry_reg;
   logic                    accept;
   logic                    last;

   assign accept = in_valid & in_ready;
   assign last   = (idx == LAST_IDX);
   assign sum    = sum_reg;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      rca_a     = 4'h0;
      rca_b     = 4'h0;
      rca_cin   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            // Pure register decode: the RCA never sees the request inputs directly.
            rca_a   = a_reg[idx];
            rca_b   = b_reg[idx];
            rca_cin = carry_reg;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  idx       <= '0;
               end
            end
            RUN: begin
               sum_reg[idx] <= rca_s;
               carry_reg    <= rca_cout;
               if (last) begin
                  cout      <= rca_cout;
                  out_valid <= 1'b1;
                  idx       <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit RCA
// wired to the rca_* ports.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic [3:0]  rca_a;
   logic [3:0]  rca_b;
   logic        rca_cin;
   logic [3:0]  rca_s;
   logic        rca_cout;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RCA_4Bit
   assign {rca_cout, rca_s} = rca_a + rca_b + rca_cin;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
      .rca_s(rca_s), .rca_cout(rca_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL rst_sum: got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
      n_cmp++; if ({rca_a, rca_b, rca_cin} !== 9'h000) begin n_err++; $display("FAIL rst_rca: got %h/%h/%b want 0/0/0", rca_a, rca_b, rca_cin); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [3:0] exp_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
      logic [3:0] exp_b [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
      a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rca_a !== exp_a[i]) begin n_err++; $display("FAIL basic_rca_a[%0d]: got %h want %h", i, rca_a, exp_a[i]); end
         n_cmp++; if (rca_b !== exp_b[i]) begin n_err++; $display("FAIL basic_rca_b[%0d]: got %h want %h", i, rca_b, exp_b[i]); end
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid); end
         tick();
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: out_valid %b want 1", out_valid); end
      n_cmp++; if (sum !== 16'h5555) begin n_err++; $display("FAIL basic_sum: got %h want 5555", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b want 0", cout); end
      n_cmp++; if (rca_a !== 4'h0) begin n_err++; $display("FAIL basic_done_rca_a: got %h want 0", rca_a); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL basic_consume: valid/ready %b%b want 01", out_valid, in_ready); end
   endtask

   task automatic test_carry_chain();
      a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rca_cin !== 1'b1) begin n_err++; $display("FAIL carry_rca_cin[%0d]: got %b want 1", i, rca_cin); end
         tick();
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL carry_valid: got %b want 1", out_valid); end
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL carry_sum: got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry_cout: got %b want 1", cout); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      // Pending request offered while the result is stalled
      a = 16'h0003; b = 16'h0004; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
         n_cmp++; if ({cout, sum} !== 17'h10000) begin n_err++; $display("FAIL bp_result[%0d]: got %b_%h want 1_0000", i, cout, sum); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: valid/ready %b%b want 01", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if ({in_ready, rca_a, rca_b} !== 9'h034) begin n_err++; $display("FAIL bp_pending_accept: ready/a/b %b/%h/%h want 0/3/4", in_ready, rca_a, rca_b); end
      repeat (4) tick();
      n_cmp++; if ({out_valid, cout, sum} !== 18'h20007) begin n_err++; $display("FAIL bp_pending_result: %b/%b/%h want 1/0/0007", out_valid, cout, sum); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      n_cmp++; if (rca_a !== 4'h1 || rca_b !== 4'h2) begin n_err++; $display("FAIL midrst_pre: rca %h/%h want 1/2", rca_a, rca_b); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({out_valid, in_ready, rca_a, rca_b, rca_cin} !== 11'b01_0000_0000_0) begin n_err++; $display("FAIL midrst_async: valid/ready/rca %b/%b/%h/%h/%b want 0/1/0/0/0", out_valid, in_ready, rca_a, rca_b, rca_cin); end
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_valid[%0d]: got %b want 0", i, out_valid); end
      end
      a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      n_cmp++; if ({out_valid, cout, sum} !== 18'h20002) begin n_err++; $display("FAIL midrst_next: %b/%b/%h want 1/0/0002", out_valid, cout, sum); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [3] = '{16'h00FF, 16'hABCD, 16'hFFFF};
      logic [15:0] vb [3] = '{16'h0001, 16'h1111, 16'hFFFF};
      logic        vc [3] = '{1'b0, 1'b1, 1'b0};
      logic [16:0] exp [3] = '{17'h00100, 17'h0BCDF, 17'h1FFFE};
      int prev_cyc = 0;
      out_ready = 1'b1;
      a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept[%0d]: in_ready %b want 0", k, in_ready); end
         if (k < 2) begin a = va[k+1]; b = vb[k+1]; cin = vc[k+1]; end
         else in_valid = 1'b0;
         repeat (3) tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early[%0d]: out_valid %b want 0", k, out_valid); end
         tick();
         n_cmp++; if ({out_valid, cout, sum} !== {1'b1, exp[k]}) begin n_err++; $display("FAIL b2b_result[%0d]: %b/%b/%h want 1/%b/%h", k, out_valid, cout, sum, exp[k][16], exp[k][15:0]); end
         if (k > 0) begin
            n_cmp++; if (cyc - prev_cyc !== 6) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", k, cyc - prev_cyc); end
         end
         prev_cyc = cyc;
         tick();
         n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_idle[%0d]: valid/ready %b%b want 01", k, out_valid, in_ready); end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_chain();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
